// File: rtl/calc_pkg.sv
// Shared constants, types and the priority-encode helper for the push-switch
// key encoder.
package calc_pkg;

  localparam int PSW_W  = 14;
  localparam int CODE_W = 4;

  typedef logic [CODE_W-1:0] key_code_t;

  // Function keys. Digits 0-9 use their own switch index as the code.
  localparam key_code_t KEY_ADD = 4'd10;
  localparam key_code_t KEY_SUB = 4'd11;
  localparam key_code_t KEY_EQ  = 4'd12;
  localparam key_code_t KEY_CLR = 4'd13;

  // One candidate event per tick: whether any key rose, and which one wins.
  typedef struct packed {
    logic      hit;
    key_code_t code;
  } key_evt_t;

  // Lowest-index rising key wins. The other keys that rose on the same tick
  // are dropped, and they need a release and re-press to be seen again.
  function automatic key_evt_t lowest_rise(input logic [PSW_W-1:0] rise);
    key_evt_t evt;
    // NOTE: give every combinational output a default before any conditional
    // assignment, so that no path leaves it unassigned and no latch is inferred.
    evt = '0;
    for (int i = PSW_W - 1; i >= 0; i--) begin
      if (rise[i]) begin
        evt.hit  = 1'b1;
        evt.code = key_code_t'(i);
      end
    end
    return evt;
  endfunction

endpackage

// File: rtl/psw_key_encoder_if.sv
// Key event stream from the encoder to its consumer: a valid/ready handshake
// plus the sticky overflow flag.
interface psw_key_encoder_if;
  import calc_pkg::*;

  logic      KEY_VALID;
  key_code_t KEY_CODE;
  logic      KEY_READY;
  logic      KEY_OVF;

  modport master (output KEY_VALID, output KEY_CODE, output KEY_OVF, input KEY_READY);
  modport slave  (input KEY_VALID, input KEY_CODE, input KEY_OVF, output KEY_READY);
endinterface

// File: rtl/psw_debounce.sv
// Debounces one push switch. The raw input goes through a 2-flop
// synchronizer. On each tick the synchronized value is shifted into a
// history. The debounced state changes only when the whole history agrees.
// A one-cycle rise pulse follows each debounced 0->1 edge.
module psw_debounce #(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic psw_raw,
  output logic rise
);

  logic [1:0]             sync_q;
  logic [DEB_SAMPLES-1:0] hist_q;
  logic [DEB_SAMPLES-1:0] hist_next;
  logic                   deb_q;

  // The history after this tick's shift. The state decision uses the
  // newest sample.
  assign hist_next = {hist_q[DEB_SAMPLES-2:0], sync_q[1]};

  // Two-flop synchronizer for the asynchronous switch input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: use non-blocking assignments for all flop state, so that every
      // register samples the value from before the edge. Blocking assignments
      // here would merge the two synchronizer stages into one.
      sync_q <= {sync_q[0], psw_raw};
    end
  end

  // Update the sample history and debounced state on ticks. Generate the
  // rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      deb_q  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (tick) begin
        hist_q <= hist_next;
        if (&hist_next) begin
          deb_q <= 1'b1;
          rise  <= ~deb_q;
        end else if (~|hist_next) begin
          deb_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/psw_key_encoder.sv
// Push-switch key encoder. It debounces PSW_W switches on a shared sample
// tick and keeps the lowest-index press of each tick. The result goes into a
// 2-entry FIFO. Events that are dropped because the FIFO is full set a
// sticky overflow flag. The clear key flushes the FIFO and then stands as
// the only entry.
module psw_key_encoder
  import calc_pkg::*;
#(
  parameter int DEB_TICK    = 250000,
  parameter int DEB_SAMPLES = 4
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [PSW_W-1:0]   PSW,
  psw_key_encoder_if.master  key
);

  localparam int TICK_W = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;

  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;
  logic [PSW_W-1:0]  rise;
  key_evt_t          evt;

  key_code_t         fifo_mem [2];
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              ovf_q;

  logic              valid;
  logic              full;
  logic              pop;
  logic              push_ok;
  logic              wr_ptr;
  logic              clr_evt;

  assign tick = (tick_cnt_q == TICK_W'(DEB_TICK - 1));

  // Free-running sample tick counter. It wraps after DEB_TICK cycles.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_W'(1);
    end
  end

  for (genvar b = 0; b < PSW_W; b++) begin : g_deb
    psw_debounce #(
      .DEB_SAMPLES(DEB_SAMPLES)
    ) u_deb (
      .clk     (CLK),
      .rst_n   (RST_X),
      .tick    (tick),
      .psw_raw (PSW[b]),
      .rise    (rise[b])
    );
  end

  // Pick the winning key from this cycle's rise pulses.
  always_comb begin
    evt = lowest_rise(rise);
  end

  assign valid   = (count_q != 2'd0);
  assign full    = (count_q == 2'd2);
  assign pop     = valid && key.KEY_READY;
  assign clr_evt = evt.hit && (evt.code == KEY_CLR);
  // When full and popping, the write reuses the slot that is being freed.
  assign push_ok = evt.hit && (!full || pop);
  assign wr_ptr  = rd_ptr_q ^ count_q[0];

  // The FIFO and its overflow flag. A clear event has priority over
  // everything else.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      // NOTE: the two storage slots are reset, although their contents have
      // no meaning while empty, so that KEY_CODE reads 0 during reset.
      // Larger memories would normally be left out of reset.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      ovf_q       <= 1'b0;
    end else if (clr_evt) begin
      fifo_mem[0] <= KEY_CLR;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd1;
      ovf_q       <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= evt.code;
      end
      if (evt.hit && !push_ok) begin
        ovf_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push_ok && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (!push_ok && pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign key.KEY_VALID = valid;
  assign key.KEY_CODE  = fifo_mem[rd_ptr_q];
  assign key.KEY_OVF   = ovf_q;

endmodule

// File: tb/tb_psw_key_encoder.sv
// Testbench for psw_key_encoder with short debounce parameters. A reference
// model predicts the expected key queue and overflow flag from the debounce
// rules. A monitor compares the DUT against that model every cycle. Directed
// scenarios also check the transferred code sequence against fixed values.
module tb_psw_key_encoder;
  import calc_pkg::*;

  localparam int TB_TICK    = 4;
  localparam int TB_SAMPLES = 3;

  logic             CLK;
  logic             RST_X;
  logic [PSW_W-1:0] psw;

  psw_key_encoder_if kif ();

  psw_key_encoder #(
    .DEB_TICK    (TB_TICK),
    .DEB_SAMPLES (TB_SAMPLES)
  ) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .PSW   (psw),
    .key   (kif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected FIFO contents (head first) and the overflow flag.
  logic [3:0]       exp_q [$];
  logic             exp_ovf;

  initial begin : model
    int unsigned      edge_k;
    logic [PSW_W-1:0] psw_d1, psw_d2;
    logic [PSW_W-1:0] deb_m;
    logic [PSW_W-1:0] run_val;
    int               run_len [PSW_W];
    logic [PSW_W-1:0] rose;
    bit               pend_v;
    logic [3:0]       pend_c;
    bit               pop_m;
    exp_ovf = 1'b0;
    forever begin
      @(posedge CLK);
      if (!RST_X) begin
        edge_k  = 0;
        psw_d1  = '0;
        psw_d2  = '0;
        deb_m   = '0;
        run_val = '0;
        for (int b = 0; b < PSW_W; b++) run_len[b] = TB_SAMPLES;
        pend_v  = 1'b0;
        pend_c  = '0;
        exp_q.delete();
        exp_ovf = 1'b0;
      end else begin
        edge_k++;
        // FIFO step: this takes the event decided on the previous tick edge.
        pop_m = (exp_q.size() != 0) && kif.KEY_READY;
        if (pend_v && pend_c == KEY_CLR) begin
          exp_q.delete();
          exp_q.push_back(KEY_CLR);
          exp_ovf = 1'b0;
        end else begin
          if (pop_m) void'(exp_q.pop_front());
          if (pend_v) begin
            if (exp_q.size() < 2) exp_q.push_back(pend_c);
            else exp_ovf = 1'b1;
          end
        end
        pend_v = 1'b0;
        // A tick falls on every TB_TICK-th edge after reset. The sample it
        // takes is the PSW value from two edges earlier, through the
        // synchronizer. A key switches state after TB_SAMPLES equal samples
        // in a row.
        if (edge_k % TB_TICK == 0) begin
          rose = '0;
          for (int b = 0; b < PSW_W; b++) begin
            if (psw_d2[b] == run_val[b]) run_len[b]++;
            else begin
              run_val[b] = psw_d2[b];
              run_len[b] = 1;
            end
            if (run_len[b] >= TB_SAMPLES) begin
              if (run_val[b] && !deb_m[b]) rose[b] = 1'b1;
              deb_m[b] = run_val[b];
            end
          end
          for (int b = PSW_W - 1; b >= 0; b--) begin
            if (rose[b]) begin
              pend_v = 1'b1;
              pend_c = 4'(b);
            end
          end
        end
        psw_d2 = psw_d1;
        psw_d1 = psw;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    forever begin
      @(posedge CLK);
      #1;
      if (RST_X) begin
        check("valid", kif.KEY_VALID, exp_q.size() != 0);
        if (exp_q.size() != 0) check("code", kif.KEY_CODE, exp_q[0]);
        check("ovf", kif.KEY_OVF, exp_ovf);
      end
    end
  end

  // Log of codes the DUT actually transferred, for the directed checks.
  logic [3:0] xfer_log [$];
  initial begin : xfer_mon
    forever begin
      @(posedge CLK);
      if (RST_X === 1'b1 && kif.KEY_VALID === 1'b1 && kif.KEY_READY === 1'b1)
        xfer_log.push_back(kif.KEY_CODE);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit          rand_ready = 1'b0;
  int unsigned ready_pct  = 70;

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (rand_ready) kif.KEY_READY = ($urandom_range(99, 0) < ready_pct);
    end
  endtask

  task automatic press_release(input int b, input int hold, input int rel);
    psw[b] = 1'b1;
    idle(hold);
    psw[b] = 1'b0;
    idle(rel);
  endtask

  task automatic bounce_rand(input int b, input int cycles);
    int  left;
    int  len;
    logic lvl;
    lvl  = 1'b1;
    left = cycles;
    while (left > 0) begin
      len = int'($urandom_range(6, 1));
      if (len > left) len = left;
      psw[b] = lvl;
      idle(len);
      left -= len;
      lvl = ~lvl;
    end
    psw[b] = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [3:0] a, input logic [3:0] b, input int n);
    check({name, "_cnt"}, xfer_log.size(), n);
    if (n >= 1 && xfer_log.size() >= 1) check({name, "_0"}, xfer_log[0], a);
    if (n >= 2 && xfer_log.size() >= 2) check({name, "_1"}, xfer_log[1], b);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int kind;
    int b1;
    int b2;
    RST_X         = 1'b0;
    psw           = '0;
    kif.KEY_READY = 1'b0;
    #1;
    check("rst_valid", kif.KEY_VALID, 1'b0);
    check("rst_code", kif.KEY_CODE, 4'd0);
    check("rst_ovf", kif.KEY_OVF, 1'b0);
    idle(3);
    RST_X = 1'b1;
    idle(2);

    // Holding key 5 gives exactly one event, and the release gives none.
    kif.KEY_READY = 1'b1;
    xfer_log.delete();
    press_release(5, 40, 40);
    check_log("hold5", 4'd5, 4'd0, 1);

    // A bounce with 6-cycle levels never gives 3 equal samples in a row.
    xfer_log.delete();
    for (int i = 0; i < 7; i++) begin
      psw[3] = ~i[0];
      idle(6);
    end
    psw[3] = 1'b0;
    idle(30);
    check_log("bounce3", 4'd0, 4'd0, 0);

    // Three presses with the consumer stalled overflow the FIFO.
    kif.KEY_READY = 1'b0;
    xfer_log.delete();
    press_release(1, 25, 25);
    press_release(2, 25, 25);
    press_release(7, 25, 25);
    check("ovf_set", kif.KEY_OVF, 1'b1);
    kif.KEY_READY = 1'b1;
    idle(5);
    check_log("drain", 4'd1, 4'd2, 2);
    check("drain_empty", kif.KEY_VALID, 1'b0);

    // The clear key flushes {1,2}, clears the overflow and leaves only 13.
    kif.KEY_READY = 1'b0;
    press_release(1, 25, 25);
    press_release(2, 25, 25);
    press_release(7, 25, 25);
    check("ovf_again", kif.KEY_OVF, 1'b1);
    press_release(13, 25, 25);
    check("clr_ovf", kif.KEY_OVF, 1'b0);
    check("clr_valid", kif.KEY_VALID, 1'b1);
    check("clr_code", kif.KEY_CODE, KEY_CLR);
    xfer_log.delete();
    kif.KEY_READY = 1'b1;
    idle(5);
    check_log("clr_only", KEY_CLR, 4'd0, 1);

    // Keys 4 and 9 rise together: only 4 is seen. Key 9 is seen after it is
    // released and pressed again.
    xfer_log.delete();
    psw[4] = 1'b1;
    psw[9] = 1'b1;
    idle(30);
    psw[4] = 1'b0;
    idle(30);
    check_log("dual_a", 4'd4, 4'd0, 1);
    psw[9] = 1'b0;
    idle(30);
    psw[9] = 1'b1;
    idle(30);
    psw[9] = 1'b0;
    idle(30);
    check_log("dual_b", 4'd4, 4'd9, 2);

    // Reset with one queued entry takes effect at once. Key 0 held through
    // reset gives one event.
    kif.KEY_READY = 1'b0;
    psw[1] = 1'b1;
    idle(30);
    check("pre_rst_valid", kif.KEY_VALID, 1'b1);
    psw    = '0;
    psw[0] = 1'b1;
    #2;
    RST_X = 1'b0;
    #1;
    check("async_valid", kif.KEY_VALID, 1'b0);
    check("async_code", kif.KEY_CODE, 4'd0);
    check("async_ovf", kif.KEY_OVF, 1'b0);
    idle(3);
    RST_X = 1'b1;
    xfer_log.delete();
    kif.KEY_READY = 1'b1;
    idle(40);
    check_log("held0", 4'd0, 4'd0, 1);
    psw[0] = 1'b0;
    idle(30);

    // Randomized traffic, checked by the monitor against the model.
    rand_ready = 1'b1;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(2, 0))
        0:       ready_pct = 20;
        1:       ready_pct = 70;
        default: ready_pct = 100;
      endcase
      kind = int'($urandom_range(7, 0));
      b1   = int'($urandom_range(PSW_W - 1, 0));
      b2   = int'($urandom_range(PSW_W - 1, 0));
      if (kind < 6) begin
        press_release(b1, int'($urandom_range(40, 20)), int'($urandom_range(40, 20)));
      end else if (kind == 6) begin
        psw[b1] = 1'b1;
        psw[b2] = 1'b1;
        idle(int'($urandom_range(40, 20)));
        psw = '0;
        idle(int'($urandom_range(40, 20)));
      end else begin
        bounce_rand(b1, 30);
        idle(25);
      end
    end
    rand_ready    = 1'b0;
    kif.KEY_READY = 1'b1;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
